// File: rtl/pulse_timer_arbiter.sv
// Purpose: round-robin shares one timed-pulse generator among NREQ level requesters.
// Latency: request seen at edge T drives dout/grant on T+1..T+len, done at T+len+1, then GAP idle cycles.
// Backpressure: requesters hold req until done; dropping req mid-pulse aborts it with no done.
module pulse_timer_arbiter #(
   parameter int  NREQ  = 4,
   parameter int  CNT_W = 8,
   parameter int  GAP   = 2,
   localparam int IDX_W = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*CNT_W-1:0] len_i,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       done,
   output logic                  dout,
   output logic                  busy,
   output logic [IDX_W-1:0]      owner
);

   // Gap counter needs at least one bit even when GAP is 0 or 1.
   localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [GAP_W-1:0]  r_gap;
   logic [GAP_W-1:0]  w_gap_nxt;
   logic [IDX_W-1:0]  r_ptr;
   logic [IDX_W-1:0]  w_ptr_nxt;
   logic [IDX_W-1:0]  w_owner_nxt;
   logic [IDX_W-1:0]  w_pick;
   logic [IDX_W-1:0]  w_cand;
   logic [IDX_W:0]    w_sum;
   logic              w_found;
   logic [CNT_W-1:0]  w_len_arr [NREQ];
   logic [CNT_W-1:0]  w_len;
   logic [NREQ-1:0]   w_grant_nxt;
   logic [NREQ-1:0]   w_done_nxt;
   logic              w_dout_nxt;

   // Split the packed length bus into per-requester fields and select the winner's.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_len_arr[i] = len_i[i*CNT_W +: CNT_W];
      end
      w_len = w_len_arr[w_pick];
   end

   // Round-robin search: first asserted request scanning upward from r_ptr, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_sum   = '0;
      w_cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
         if (w_sum >= (IDX_W+1)'(NREQ)) begin
            w_sum = w_sum - (IDX_W+1)'(NREQ);
         end
         w_cand = IDX_W'(w_sum);
         if (!w_found && req[w_cand]) begin
            w_found = 1'b1;
            w_pick  = w_cand;
         end
      end
   end

   // Next-state and next-output decode; outputs are registered below.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_gap_nxt   = r_gap;
      w_ptr_nxt   = r_ptr;
      w_owner_nxt = owner;
      w_grant_nxt = '0;
      w_done_nxt  = '0;
      w_dout_nxt  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt         = S_RUN;
               w_grant_nxt[w_pick] = 1'b1;
               w_owner_nxt         = w_pick;
               w_dout_nxt          = 1'b1;
               // A zero length still produces a one-cycle pulse.
               w_cnt_nxt           = (w_len == '0) ? CNT_W'(1) : w_len;
               w_ptr_nxt           = (w_pick == IDX_W'(NREQ-1)) ? '0 : w_pick + 1'b1;
            end
         end
         S_RUN: begin
            if (req[owner] && (r_cnt > CNT_W'(1))) begin
               w_cnt_nxt   = r_cnt - 1'b1;
               w_grant_nxt = grant;
               w_dout_nxt  = 1'b1;
            end else begin
               // Either the last cycle (done) or the owner dropped req (abort, no done).
               w_done_nxt[owner] = req[owner];
               w_cnt_nxt         = '0;
               if (GAP == 0) begin
                  w_state_nxt = S_IDLE;
               end else begin
                  w_state_nxt = S_GAP;
                  w_gap_nxt   = GAP_W'(GAP);
               end
            end
         end
         S_GAP: begin
            if (r_gap <= GAP_W'(1)) begin
               w_state_nxt = S_IDLE;
               w_gap_nxt   = '0;
            end else begin
               w_gap_nxt = r_gap - 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, counters and all outputs; asynchronous reset clears everything.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_gap   <= '0;
         r_ptr   <= '0;
         owner   <= '0;
         grant   <= '0;
         done    <= '0;
         dout    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_gap   <= w_gap_nxt;
         r_ptr   <= w_ptr_nxt;
         owner   <= w_owner_nxt;
         grant   <= w_grant_nxt;
         done    <= w_done_nxt;
         dout    <= w_dout_nxt;
         busy    <= (w_state_nxt != S_IDLE);
      end
   end

endmodule
